// File: rtl/spi_mem_slave.sv
// spi_mem_slave
//   SPI slave in front of a 2^ADDR_W x DATA_W register-array RAM. The first
//   frame of a transaction is an 8-bit command. Every later frame is DATA_W
//   bits wide and is handled according to that command until SSB rises.
//   A handshaked sampler streams N words from ext_data into RAM.
//   Commands: WR_AR, WR_DATA, RD_DATA, SAMPLE, RD_STATUS, ABORT.
//   cmd[4] = AUTOINC.
// Ports
//   SCK        clock, all logic on the rising edge
//   reset      asynchronous, active-high
//   SSB        slave select, active low
//   MOSI       serial in, MSB first
//   MISO       serial out, MSB first (transmit register MSB)
//   ext_data   sample word
//   ext_valid  ext_data valid this cycle (ignored unless busy)
//   busy       sampler running
//   done       sticky sampler-complete flag
module spi_mem_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              SCK,
  input  logic              reset,
  input  logic              SSB,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              ext_valid,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = 1 << ADDR_W;
  // The receive path must hold a full command byte even when DATA_W < 8.
  localparam int RX_W  = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = $clog2(RX_W + 1);

  localparam logic [3:0] OP_WR_AR     = 4'h1;
  localparam logic [3:0] OP_WR_DATA   = 4'h2;
  localparam logic [3:0] OP_RD_DATA   = 4'h3;
  localparam logic [3:0] OP_SAMPLE    = 4'h4;
  localparam logic [3:0] OP_RD_STATUS = 4'h5;
  localparam logic [3:0] OP_ABORT     = 4'h6;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [RX_W-2:0]   rx_reg, rx_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [4:0]        cmd_reg, cmd_next;
  logic              first_reg, first_next;
  logic [ADDR_W-1:0] ar_reg, ar_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rem_reg, rem_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [RX_W-1:0]   shift_in;
  logic [DATA_W-1:0] frame;
  logic [4:0]        cmd_word;
  logic [3:0]        op;
  logic              autoinc;
  logic              cmd_end;
  logic              frame_end;
  logic [DATA_W-1:0] status_word;

  always_ff @(posedge SCK or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rx_reg    <= '0;
      tx_reg    <= '0;
      cmd_reg   <= '0;
      first_reg <= 1'b0;
      ar_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rx_reg    <= rx_next;
      tx_reg    <= tx_next;
      cmd_reg   <= cmd_next;
      first_reg <= first_next;
      ar_reg    <= ar_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rem_reg   <= rem_next;
    end
  end

  // RAM contents survive reset; only the write strobe is held off.
  always_ff @(posedge SCK) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rx_next     = rx_reg;
    tx_next     = tx_reg;
    cmd_next    = cmd_reg;
    first_next  = first_reg;
    ar_next     = ar_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;
    err_next    = err_reg;
    rem_next    = rem_reg;
    we          = 1'b0;
    waddr       = ar_reg;
    wdata       = ext_data;
    cmd_end     = 1'b0;
    frame_end   = 1'b0;
    status_word = '0;

    shift_in = {rx_reg, MOSI};
    frame    = shift_in[DATA_W-1:0];
    // While the command byte is completing, decode it straight off the wire.
    cmd_word = (state_reg == S_CMD) ? shift_in[4:0] : cmd_reg;
    op       = cmd_word[3:0];
    autoinc  = cmd_word[4];

    // Sampler runs independently of SSB and owns AR while busy.
    if (busy_reg && ext_valid) begin
      we       = 1'b1;
      waddr    = ar_reg;
      wdata    = ext_data;
      ar_next  = ar_reg + ADDR_W'(1);
      rem_next = rem_reg - DATA_W'(1);
      if (rem_reg == DATA_W'(1)) begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
    end

    if (SSB) begin
      // Partial frames and the current command are dropped.
      state_next = S_IDLE;
      cnt_next   = '0;
      rx_next    = '0;
      tx_next    = '0;
      cmd_next   = '0;
      first_next = 1'b0;
    end else begin
      rx_next = shift_in[RX_W-2:0];
      tx_next = {tx_reg[DATA_W-2:0], 1'b0};
      unique case (state_reg)
        S_IDLE: begin
          state_next = S_CMD;
          cnt_next   = CNT_W'(1);
        end
        S_CMD: begin
          if (cnt_reg == CNT_W'(7)) begin
            cmd_end    = 1'b1;
            state_next = S_DATA;
            cnt_next   = '0;
            cmd_next   = shift_in[4:0];
            first_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            frame_end  = 1'b1;
            cnt_next   = '0;
            first_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end

    if (cmd_end && op == OP_ABORT) begin
      busy_next = 1'b0;
      rem_next  = '0;
    end

    if (frame_end) begin
      case (op)
        OP_WR_AR: begin
          if (busy_reg) err_next = 1'b1;
          else          ar_next  = frame[ADDR_W-1:0];
        end
        OP_WR_DATA: begin
          if (busy_reg) begin
            err_next = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = ar_reg;
            wdata = frame;
            if (autoinc) ar_next = ar_reg + ADDR_W'(1);
          end
        end
        OP_SAMPLE: begin
          // Only the first data frame carries N.
          if (first_reg) begin
            if (busy_reg) begin
              err_next = 1'b1;
            end else if (frame != '0) begin
              busy_next = 1'b1;
              rem_next  = frame;
            end
          end
        end
        default: ;
      endcase
    end

    // Transmit register reloads at every frame boundary.
    if (cmd_end || frame_end) begin
      case (op)
        OP_RD_DATA: begin
          if (busy_reg) begin
            err_next = 1'b1;
            tx_next  = '0;
          end else begin
            tx_next = mem[ar_reg];
            if (autoinc) ar_next = ar_reg + ADDR_W'(1);
          end
        end
        OP_RD_STATUS: begin
          // Uses post-capture sampler state so a same-edge completion shows.
          status_word[3:0] = {err_reg, done_next, busy_next, ~busy_next};
          tx_next          = status_word;
          done_next        = 1'b0;
          err_next         = 1'b0;
        end
        default: tx_next = '0;
      endcase
    end
  end

  assign MISO = tx_reg[DATA_W-1];
  assign busy = busy_reg;
  assign done = done_reg;
endmodule

// File: tb/tb_spi_mem_slave.sv
module tb_spi_mem_slave;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          SCK = 1'b0;
  logic          reset = 1'b0;
  logic          SSB = 1'b1;
  logic          MOSI = 1'b0;
  logic          ext_valid = 1'b0;
  logic [DW-1:0] ext_data = '0;
  logic          MISO;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mosi_q[$];
  logic [DW-1:0] scratch;
  int nv;

  spi_mem_slave #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .SCK(SCK), .reset(reset), .SSB(SSB), .MOSI(MOSI), .MISO(MISO),
    .ext_data(ext_data), .ext_valid(ext_valid), .busy(busy), .done(done)
  );

  always #5 SCK = ~SCK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive n bits MSB first; MISO is sampled on the falling edge before each capture.
  task automatic send_bits(input logic [DW-1:0] val, input int n, output logic [DW-1:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge SCK);
      got[i] = MISO;
      SSB    = 1'b0;
      MOSI   = val[i];
    end
  endtask

  task automatic end_txn();
    @(negedge SCK);
    SSB  = 1'b1;
    MOSI = 1'b0;
  endtask

  // Command byte then every word in mosi_q; with chk set, each data frame's
  // MISO word is compared against the head of the scoreboard.
  task automatic txn(input string tag, input logic [7:0] cmd, input bit chk);
    logic [DW-1:0] got;
    logic [DW-1:0] w;
    send_bits(cmd, 8, got);
    while (mosi_q.size() > 0) begin
      w = mosi_q.pop_front();
      send_bits(w, DW, got);
      if (chk) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s got=0x%0h exp=<scoreboard empty>", tag, got);
        end else begin
          check_eq(tag, got, exp_q.pop_front());
        end
      end
    end
    end_txn();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 reset = 1'b1;
    #1;
    check_eq("rst_miso", MISO, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    repeat (2) @(negedge SCK);
    reset = 1'b0;

    // Burst write then burst read
    mosi_q = '{8'h10};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'hA1, 8'hB2, 8'hC3};      txn("wr_burst", 8'h12, 0);
    mosi_q = '{8'hD4};                    txn("wr_at_ar", 8'h02, 0);
    mosi_q = '{8'h10};                    txn("wr_ar", 8'h01, 0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    mosi_q = '{8'h00, 8'h00, 8'h00, 8'h00}; txn("rd_burst", 8'h13, 1);

    // Address wrap
    mosi_q = '{8'hFF};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'h11, 8'h22};             txn("wr_wrap", 8'h12, 0);
    mosi_q = '{8'hFF};                    txn("wr_ar", 8'h01, 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    mosi_q = '{8'h00, 8'h00};             txn("rd_wrap", 8'h13, 1);

    // Sampler, N=4 with ext_valid toggling
    mosi_q = '{8'h20};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'h04};                    txn("sample", 8'h04, 0);
    check_eq("busy_after_sample", busy, 1);
    nv = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge SCK);
      if (i == 6) check_eq("busy_before_4th", busy, 1);
      ext_valid = (i % 2 == 1);
      if (ext_valid) begin
        ext_data = DW'(nv);
        nv++;
      end
    end
    @(negedge SCK);
    ext_valid = 1'b0;
    check_eq("busy_after_4th", busy, 0);
    check_eq("done_after_4th", done, 1);
    exp_q.push_back(8'h05); exp_q.push_back(8'h01);
    mosi_q = '{8'h00, 8'h00};             txn("status_done", 8'h05, 1);
    check_eq("done_cleared", done, 0);
    mosi_q = '{8'h20};                    txn("wr_ar", 8'h01, 0);
    for (int i = 1; i <= 4; i++) begin
      scratch = DW'(i);
      exp_q.push_back(scratch);
    end
    mosi_q = '{8'h00, 8'h00, 8'h00, 8'h00}; txn("rd_samples", 8'h13, 1);

    // Collision with a running sampler, then abort
    mosi_q = '{8'h30};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'h5A};                    txn("wr_5a", 8'h02, 0);
    mosi_q = '{8'h02};                    txn("sample2", 8'h04, 0);
    check_eq("busy_sample2", busy, 1);
    mosi_q = '{8'h77};                    txn("wr_blocked", 8'h02, 0);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h02);
    mosi_q = '{8'h00, 8'h00};             txn("status_err", 8'h05, 1);
    txn("abort", 8'h06, 0);
    check_eq("busy_after_abort", busy, 0);
    mosi_q = '{8'h30};                    txn("wr_ar", 8'h01, 0);
    exp_q.push_back(8'h5A);
    mosi_q = '{8'h00};                    txn("rd_unchanged", 8'h03, 1);

    // Truncated frame: no write, AR unchanged
    mosi_q = '{8'h40};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'h66};                    txn("wr_66", 8'h02, 0);
    send_bits(8'h12, 8, scratch);
    send_bits(8'h99, 5, scratch);
    end_txn();
    exp_q.push_back(8'h66);
    mosi_q = '{8'h00};                    txn("rd_after_trunc", 8'h03, 1);

    // Reset in the middle of a frame while busy and done are both set
    mosi_q = '{8'h50};                    txn("wr_ar", 8'h01, 0);
    mosi_q = '{8'h01};                    txn("sample1", 8'h04, 0);
    @(negedge SCK); ext_valid = 1'b1; ext_data = 8'hEE;
    @(negedge SCK); ext_valid = 1'b0;
    check_eq("done_sample1", done, 1);
    mosi_q = '{8'h03};                    txn("sample3", 8'h04, 0);
    check_eq("busy_sample3", busy, 1);
    send_bits(8'h01, 8, scratch);
    send_bits(8'hAA, 3, scratch);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_miso", MISO, 0);
    @(negedge SCK);
    SSB = 1'b1;
    reset = 1'b0;
    @(negedge SCK);
    exp_q.push_back(8'h01);
    mosi_q = '{8'h00};                    txn("status_after_rst", 8'h05, 1);
    mosi_q = '{8'h50};                    txn("wr_ar", 8'h01, 0);
    exp_q.push_back(8'hEE);
    mosi_q = '{8'h00};                    txn("ram_kept", 8'h03, 1);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
